// File: rtl/l2_cache_response.sv
// l2_cache_response: L2 response stage. Accepted write-stage requests are
// formatted into a response record and queued in a 4-entry FIFO whose head
// drives the l2rsp_* outputs. rsp_stall throttles the pipeline at 3 entries,
// leaving room for the one request that is already past the stall point.
//
// Request op encoding (wr_l2req_op): 0 LOAD, 1 STORE, 2 FLUSH, 3 INVALIDATE,
// 4 LOAD_SYNC, 5 STORE_SYNC; codes 6/7 are answered as load acks.
// Response op encoding (l2rsp_op): 0 load ack, 1 store ack, 2 flush, 3 invalidate.
// Unit 0 selects the core0 directory vectors, unit 1 the core1 vectors
// (selection uses unit bit 0).
//
// Optional feature: define L2_RSP_OVERFLOW_CHECK_EN to record dropped
// enqueues in the sticky rsp_overflow flag.

`ifndef NUM_CORES
`define NUM_CORES 2
`endif

module l2_cache_response #(
  parameter int DATA_W = 512
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      stall_pipeline,
  input  logic                      wr_l2req_valid,
  input  logic [1:0]                wr_l2req_core,
  input  logic [1:0]                wr_l2req_unit,
  input  logic [1:0]                wr_l2req_strand,
  input  logic [2:0]                wr_l2req_op,
  input  logic [1:0]                wr_l2req_way,
  input  logic                      wr_cache_hit,
  input  logic                      wr_has_sm_data,
  input  logic                      wr_store_sync_success,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [`NUM_CORES-1:0]     wr_l1_has_line_core0,
  input  logic [`NUM_CORES-1:0]     wr_l1_has_line_core1,
  input  logic [2*`NUM_CORES-1:0]   wr_dir_l1_way_core0,
  input  logic [2*`NUM_CORES-1:0]   wr_dir_l1_way_core1,
  input  logic                      l2rsp_ready,
  output logic                      l2rsp_valid,
  output logic                      l2rsp_status,
  output logic [1:0]                l2rsp_core,
  output logic [1:0]                l2rsp_unit,
  output logic [1:0]                l2rsp_strand,
  output logic [1:0]                l2rsp_way,
  output logic [1:0]                l2rsp_op,
  output logic [`NUM_CORES-1:0]     l2rsp_update,
  output logic [DATA_W-1:0]         l2rsp_data,
  output logic                      rsp_stall,
  output logic                      rsp_overflow
);

  localparam int C = `NUM_CORES;

  localparam logic [2:0] OP_LOAD       = 3'd0;
  localparam logic [2:0] OP_STORE      = 3'd1;
  localparam logic [2:0] OP_FLUSH      = 3'd2;
  localparam logic [2:0] OP_INVALIDATE = 3'd3;
  localparam logic [2:0] OP_LOAD_SYNC  = 3'd4;
  localparam logic [2:0] OP_STORE_SYNC = 3'd5;

  localparam logic [1:0] RSP_LOAD_ACK  = 2'd0;
  localparam logic [1:0] RSP_STORE_ACK = 2'd1;
  localparam logic [1:0] RSP_FLUSH     = 2'd2;
  localparam logic [1:0] RSP_INVAL     = 2'd3;

  typedef struct packed {
    logic [1:0]        core;
    logic [1:0]        unit;
    logic [1:0]        strand;
    logic [1:0]        way;
    logic [1:0]        op;
    logic              status;
    logic [C-1:0]      update;
    logic [DATA_W-1:0] data;
  } entry_t;

  function automatic logic [1:0] map_op(input logic [2:0] op);
    case (op)
      OP_LOAD, OP_LOAD_SYNC:   map_op = RSP_LOAD_ACK;
      OP_STORE, OP_STORE_SYNC: map_op = RSP_STORE_ACK;
      OP_FLUSH:                map_op = RSP_FLUSH;
      OP_INVALIDATE:           map_op = RSP_INVAL;
      default:                 map_op = RSP_LOAD_ACK;
    endcase
  endfunction

  entry_t         entry_p0;
  logic           vld_p0;
  logic           deq;
  logic           enq_ok;
  logic [2:0]     count;
  logic [1:0]     wr_ptr;
  logic [1:0]     rd_ptr;
  logic [C-1:0]   sel_line;
  logic [2*C-1:0] sel_way;
  logic [1:0]     dir_way;
  logic           is_store;
  entry_t         mem [4];
  entry_t         head;

  // Stage p0: qualify the request and format the response record
  always_comb begin
    vld_p0   = wr_l2req_valid && !stall_pipeline && (wr_cache_hit || wr_has_sm_data);
    is_store = (wr_l2req_op == OP_STORE) || (wr_l2req_op == OP_STORE_SYNC);
    sel_line = wr_l2req_unit[0] ? wr_l1_has_line_core1 : wr_l1_has_line_core0;
    sel_way  = wr_l2req_unit[0] ? wr_dir_l1_way_core1 : wr_dir_l1_way_core0;
    dir_way  = 2'd0;
    for (int i = 0; i < C; i++)
      if (wr_l2req_core == 2'(i)) dir_way = sel_way[i*2 +: 2];
    entry_p0.core   = wr_l2req_core;
    entry_p0.unit   = wr_l2req_unit;
    entry_p0.strand = wr_l2req_strand;
    entry_p0.op     = map_op(wr_l2req_op);
    entry_p0.status = !((wr_l2req_op == OP_STORE_SYNC) && !wr_store_sync_success);
    entry_p0.way    = is_store ? dir_way : wr_l2req_way;
    entry_p0.update = (is_store && entry_p0.status) ? sel_line : '0;
    entry_p0.data   = wr_data;
  end

  // A full FIFO only takes a new entry when the head leaves on the same edge
  assign deq       = l2rsp_valid && l2rsp_ready;
  assign enq_ok    = vld_p0 && ((count != 3'd4) || deq);
  assign rsp_stall = (count >= 3'd3);

  // Stage p1: entry storage, written at the accepting edge (data is not reset)
  always_ff @(posedge clk) begin
    if (enq_ok) mem[wr_ptr] <= entry_p0;
  end

  // Occupancy and pointer bookkeeping
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 3'd0;
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
    end else begin
      if (enq_ok) wr_ptr <= wr_ptr + 2'd1;
      if (deq)    rd_ptr <= rd_ptr + 2'd1;
      if (enq_ok && !deq)      count <= count + 3'd1;
      else if (!enq_ok && deq) count <= count - 3'd1;
    end
  end

  // Head outputs are forced to zero while empty so reset shows a clean bus
  assign head         = mem[rd_ptr];
  assign l2rsp_valid  = (count != 3'd0);
  assign l2rsp_status = l2rsp_valid ? head.status : 1'b0;
  assign l2rsp_core   = l2rsp_valid ? head.core   : 2'd0;
  assign l2rsp_unit   = l2rsp_valid ? head.unit   : 2'd0;
  assign l2rsp_strand = l2rsp_valid ? head.strand : 2'd0;
  assign l2rsp_way    = l2rsp_valid ? head.way    : 2'd0;
  assign l2rsp_op     = l2rsp_valid ? head.op     : 2'd0;
  assign l2rsp_update = l2rsp_valid ? head.update : '0;
  assign l2rsp_data   = l2rsp_valid ? head.data   : '0;

`ifdef L2_RSP_OVERFLOW_CHECK_EN
  logic drop;
  logic overflow_q;

  assign drop         = vld_p0 && !enq_ok;
  assign rsp_overflow = overflow_q;

  // Sticky record of any request lost to a full FIFO
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  overflow_q <= 1'b0;
    else if (drop) overflow_q <= 1'b1;
  end

`ifndef SYNTHESIS
  // Simulation-only report of a dropped request
  always @(posedge clk) begin
    if (reset_n && drop) $display("ERROR l2_cache_response: response FIFO overflow, request dropped at %0t", $time);
  end
`endif
`else
  assign rsp_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_l2_cache_response.sv
// Scoreboard bench for l2_cache_response: directed requests push their
// hand-computed responses into a queue; a negedge monitor compares the
// presented head against the queue front and pops on handshake.

`ifndef NUM_CORES
`define NUM_CORES 2
`endif

module tb_l2_cache_response;

`ifdef L2_RSP_OVERFLOW_CHECK_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset_n;
  logic         stall_pipeline;
  logic         wr_l2req_valid;
  logic [1:0]   wr_l2req_core, wr_l2req_unit, wr_l2req_strand, wr_l2req_way;
  logic [2:0]   wr_l2req_op;
  logic         wr_cache_hit, wr_has_sm_data, wr_store_sync_success;
  logic [511:0] wr_data;
  logic [1:0]   wr_l1_has_line_core0, wr_l1_has_line_core1;
  logic [3:0]   wr_dir_l1_way_core0, wr_dir_l1_way_core1;
  logic         l2rsp_ready;
  logic         l2rsp_valid, l2rsp_status;
  logic [1:0]   l2rsp_core, l2rsp_unit, l2rsp_strand, l2rsp_way, l2rsp_op;
  logic [1:0]   l2rsp_update;
  logic [511:0] l2rsp_data;
  logic         rsp_stall, rsp_overflow;

  typedef struct packed {
    logic [1:0]   op;
    logic         status;
    logic [1:0]   core;
    logic [1:0]   unit;
    logic [1:0]   strand;
    logic [1:0]   way;
    logic [1:0]   update;
    logic [511:0] data;
  } rsp_t;

  rsp_t q[$];
  rsp_t e;
  int   checks = 0;
  int   errors = 0;

  l2_cache_response dut (
    .clk(clk), .reset_n(reset_n), .stall_pipeline(stall_pipeline),
    .wr_l2req_valid(wr_l2req_valid), .wr_l2req_core(wr_l2req_core),
    .wr_l2req_unit(wr_l2req_unit), .wr_l2req_strand(wr_l2req_strand),
    .wr_l2req_op(wr_l2req_op), .wr_l2req_way(wr_l2req_way),
    .wr_cache_hit(wr_cache_hit), .wr_has_sm_data(wr_has_sm_data),
    .wr_store_sync_success(wr_store_sync_success), .wr_data(wr_data),
    .wr_l1_has_line_core0(wr_l1_has_line_core0), .wr_l1_has_line_core1(wr_l1_has_line_core1),
    .wr_dir_l1_way_core0(wr_dir_l1_way_core0), .wr_dir_l1_way_core1(wr_dir_l1_way_core1),
    .l2rsp_ready(l2rsp_ready), .l2rsp_valid(l2rsp_valid), .l2rsp_status(l2rsp_status),
    .l2rsp_core(l2rsp_core), .l2rsp_unit(l2rsp_unit), .l2rsp_strand(l2rsp_strand),
    .l2rsp_way(l2rsp_way), .l2rsp_op(l2rsp_op), .l2rsp_update(l2rsp_update),
    .l2rsp_data(l2rsp_data), .rsp_stall(rsp_stall), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Drive one request across one rising edge; push the expected response if it should be accepted
  task automatic issue(input logic [2:0] op, input logic [1:0] core, input logic [1:0] unit,
                       input logic [1:0] strand, input logic [1:0] way, input logic hit,
                       input logic sm, input logic sync, input logic stall, input logic [511:0] data,
                       input logic [1:0] hl0, input logic [1:0] hl1, input logic [3:0] dw0,
                       input logic [3:0] dw1, input logic acc, input logic [1:0] x_op,
                       input logic x_status, input logic [1:0] x_way, input logic [1:0] x_upd);
    rsp_t r;
    wr_l2req_valid = 1'b1; wr_l2req_op = op; wr_l2req_core = core; wr_l2req_unit = unit;
    wr_l2req_strand = strand; wr_l2req_way = way; wr_cache_hit = hit; wr_has_sm_data = sm;
    wr_store_sync_success = sync; stall_pipeline = stall; wr_data = data;
    wr_l1_has_line_core0 = hl0; wr_l1_has_line_core1 = hl1;
    wr_dir_l1_way_core0 = dw0; wr_dir_l1_way_core1 = dw1;
    if (acc) begin
      r.op = x_op; r.status = x_status; r.core = core; r.unit = unit; r.strand = strand;
      r.way = x_way; r.update = x_upd; r.data = data;
      q.push_back(r);
    end
    @(posedge clk); #1;
    wr_l2req_valid = 1'b0;
    stall_pipeline = 1'b0;
  endtask

  task automatic wait_empty(input string nm);
    for (int i = 0; i < 40 && q.size() != 0; i++) @(posedge clk);
    chk(nm, 512'(q.size()), 512'd0);
    #1;
  endtask

  // Monitor: compare the presented head to the scoreboard front; pop on handshake
  always @(negedge clk) begin
    if (reset_n && l2rsp_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_rsp", 512'(l2rsp_valid), 512'd0);
      end else begin
        e = q[0];
        chk("rsp_op",     512'(l2rsp_op),     512'(e.op));
        chk("rsp_status", 512'(l2rsp_status), 512'(e.status));
        chk("rsp_core",   512'(l2rsp_core),   512'(e.core));
        chk("rsp_unit",   512'(l2rsp_unit),   512'(e.unit));
        chk("rsp_strand", 512'(l2rsp_strand), 512'(e.strand));
        chk("rsp_way",    512'(l2rsp_way),    512'(e.way));
        chk("rsp_update", 512'(l2rsp_update), 512'(e.update));
        chk("rsp_data",   l2rsp_data,         e.data);
        if (l2rsp_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [511:0] a5, d1, d2, d3, d4, d5, d6;
    a5 = {64{8'hA5}};
    d1 = {16{32'h1111_0001}}; d2 = {16{32'h2222_0002}}; d3 = {16{32'h3333_0003}};
    d4 = {16{32'h4444_0004}}; d5 = {16{32'h5555_0005}}; d6 = {16{32'h6666_0006}};
    reset_n = 1'b0; stall_pipeline = 1'b0; wr_l2req_valid = 1'b0; wr_l2req_core = 2'd0;
    wr_l2req_unit = 2'd0; wr_l2req_strand = 2'd0; wr_l2req_way = 2'd0; wr_l2req_op = 3'd0;
    wr_cache_hit = 1'b0; wr_has_sm_data = 1'b0; wr_store_sync_success = 1'b0; wr_data = '0;
    wr_l1_has_line_core0 = 2'd0; wr_l1_has_line_core1 = 2'd0;
    wr_dir_l1_way_core0 = 4'd0; wr_dir_l1_way_core1 = 4'd0; l2rsp_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_valid",    512'(l2rsp_valid),  512'd0);
    chk("rst_stall",    512'(rsp_stall),    512'd0);
    chk("rst_overflow", 512'(rsp_overflow), 512'd0);
    chk("rst_data",     l2rsp_data,         512'd0);
    chk("rst_op_upd",   512'({l2rsp_op, l2rsp_update, l2rsp_status}), 512'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Load hit: one-cycle latency, single response
    issue(3'd0, 2'd1, 2'd2, 2'd3, 2'd2, 1, 0, 0, 0, a5, 2'b11, 2'b11, 4'hF, 4'hF, 1, 2'd0, 1, 2'd2, 2'b00);
    @(negedge clk); chk("load_valid_1cyc", 512'(l2rsp_valid), 512'd1);
    @(negedge clk); chk("load_valid_gone", 512'(l2rsp_valid), 512'd0);
    @(posedge clk); #1;

    // Store-sync fail / success, plain store on unit 1, flush, invalidate, load-sync, sm-data store
    issue(3'd5, 2'd0, 2'd0, 2'd1, 2'd3, 1, 0, 0, 0, d1, 2'b10, 2'b01, 4'b1001, 4'b0011, 1, 2'd1, 0, 2'd1, 2'b00);
    issue(3'd5, 2'd1, 2'd0, 2'd2, 2'd3, 1, 0, 1, 0, d2, 2'b10, 2'b01, 4'b1001, 4'b0011, 1, 2'd1, 1, 2'd2, 2'b10);
    issue(3'd1, 2'd0, 2'd1, 2'd0, 2'd0, 1, 0, 0, 0, d3, 2'b10, 2'b01, 4'b1001, 4'b0011, 1, 2'd1, 1, 2'd3, 2'b01);
    issue(3'd2, 2'd1, 2'd0, 2'd1, 2'd1, 1, 0, 0, 0, d4, 2'b11, 2'b11, 4'b1001, 4'b0011, 1, 2'd2, 1, 2'd1, 2'b00);
    issue(3'd3, 2'd0, 2'd1, 2'd2, 2'd2, 1, 0, 0, 0, d5, 2'b11, 2'b11, 4'b1001, 4'b0011, 1, 2'd3, 1, 2'd2, 2'b00);
    issue(3'd4, 2'd1, 2'd1, 2'd3, 2'd3, 1, 0, 0, 0, d6, 2'b11, 2'b11, 4'b1001, 4'b0011, 1, 2'd0, 1, 2'd3, 2'b00);
    issue(3'd1, 2'd1, 2'd1, 2'd0, 2'd0, 0, 1, 0, 0, d1, 2'b00, 2'b10, 4'b0000, 4'b0100, 1, 2'd1, 1, 2'd1, 2'b10);
    wait_empty("drain_ops");

    // Miss without sm data: no response for 5 cycles
    issue(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 0, d2, 2'b00, 2'b00, 4'h0, 4'h0, 0, 2'd0, 1, 2'd0, 2'b00);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); chk("miss_no_valid", 512'(l2rsp_valid), 512'd0);
    end
    // Stalled hit is not accepted
    @(posedge clk); #1;
    issue(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 1, d3, 2'b00, 2'b00, 4'h0, 4'h0, 0, 2'd0, 1, 2'd0, 2'b00);
    @(negedge clk); chk("stalled_no_valid", 512'(l2rsp_valid), 512'd0);
    @(posedge clk); #1;

    // Back-pressure: fill to 3 (stall), in-flight 4th stored, 5th dropped, then full+dequeue enqueue
    l2rsp_ready = 1'b0;
    issue(3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 1, 0, 0, 0, d1, 2'b00, 2'b00, 4'h0, 4'h0, 1, 2'd0, 1, 2'd0, 2'b00);
    issue(3'd2, 2'd1, 2'd0, 2'd1, 2'd1, 1, 0, 0, 0, d2, 2'b00, 2'b00, 4'h0, 4'h0, 1, 2'd2, 1, 2'd1, 2'b00);
    chk("stall_at_2", 512'(rsp_stall), 512'd0);
    issue(3'd3, 2'd0, 2'd1, 2'd2, 2'd2, 1, 0, 0, 0, d3, 2'b00, 2'b00, 4'h0, 4'h0, 1, 2'd3, 1, 2'd2, 2'b00);
    chk("stall_at_3", 512'(rsp_stall), 512'd1);
    issue(3'd4, 2'd1, 2'd1, 2'd3, 2'd3, 1, 0, 0, 0, d4, 2'b00, 2'b00, 4'h0, 4'h0, 1, 2'd0, 1, 2'd3, 2'b00);
    chk("stall_at_4", 512'(rsp_stall), 512'd1);
    issue(3'd0, 2'd2, 2'd2, 2'd0, 2'd1, 1, 0, 0, 0, d5, 2'b00, 2'b00, 4'h0, 4'h0, 0, 2'd0, 1, 2'd1, 2'b00);
    chk("overflow_flag", 512'(rsp_overflow), 512'(OVF_EN));
    chk("full_still_valid", 512'(l2rsp_valid), 512'd1);
    l2rsp_ready = 1'b1;
    issue(3'd2, 2'd3, 2'd3, 2'd1, 2'd2, 1, 0, 0, 0, d6, 2'b00, 2'b00, 4'h0, 4'h0, 1, 2'd2, 1, 2'd2, 2'b00);
    wait_empty("drain_full");
    @(negedge clk); chk("drained_valid", 512'(l2rsp_valid), 512'd0);
    chk("drained_stall",     512'(rsp_stall),    512'd0);
    chk("overflow_sticky",   512'(rsp_overflow), 512'(OVF_EN));
    @(posedge clk); #1;

    // Reset mid-stream with two queued entries
    l2rsp_ready = 1'b0;
    issue(3'd0, 2'd1, 2'd0, 2'd1, 2'd0, 1, 0, 0, 0, d1, 2'b00, 2'b00, 4'h0, 4'h0, 1, 2'd0, 1, 2'd0, 2'b00);
    issue(3'd0, 2'd2, 2'd0, 2'd2, 2'd1, 1, 0, 0, 0, d2, 2'b00, 2'b00, 4'h0, 4'h0, 1, 2'd0, 1, 2'd1, 2'b00);
    chk("pre_rst_valid", 512'(l2rsp_valid), 512'd1);
    #2 reset_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_valid",    512'(l2rsp_valid),  512'd0);
    chk("midrst_stall",    512'(rsp_stall),    512'd0);
    chk("midrst_overflow", 512'(rsp_overflow), 512'd0);
    chk("midrst_data",     l2rsp_data,         512'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    l2rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("post_rst_no_stale", 512'(l2rsp_valid), 512'd0);
    end
    @(posedge clk); #1;
    issue(3'd1, 2'd1, 2'd0, 2'd2, 2'd0, 1, 0, 0, 0, a5, 2'b01, 2'b00, 4'b1100, 4'h0, 1, 2'd1, 1, 2'd3, 2'b01);
    wait_empty("drain_resume");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/l2_cache_response.md
L2_CACHE_RESPONSE -- requirements
Module: l2_cache_response

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all state SHALL be clocked on the rising edge of clk.
REQ-002 Ports SHALL be as follows (clock and reset first); widths marked C use `NUM_CORES:
- clk  in  1  pipeline clock
- reset_n  in  1  asynchronous active-low reset
- stall_pipeline  in  1  pipeline stall; when high, the wr_* inputs hold the previous cycle's values
- wr_l2req_valid / _core / _unit / _strand / _op / _way  in  1/2/2/2/3/2  request from the write stage
- wr_cache_hit, wr_has_sm_data, wr_store_sync_success  in  1 each  request status from the write stage
- wr_data  in  512  final line data
- wr_l1_has_line_core0 / _core1  in  C  L1 directory presence per core
- wr_dir_l1_way_core0 / _core1  in  2C  L1 directory way per core
- l2rsp_ready  in  1  response consumer accepts the current response
- l2rsp_valid  out  1  response available
- l2rsp_status  out  1  1 = success, 0 = store-sync failure
- l2rsp_core / _unit / _strand / _way  out  2 each  response routing
- l2rsp_op  out  2  response type
- l2rsp_update  out  C  per-core L1 update strobe
- l2rsp_data  out  512  line data
- rsp_stall  out  1  upstream back-pressure; the top level ORs it into stall_pipeline
- rsp_overflow  out  1  sticky overflow error

Function
REQ-003 A request SHALL be accepted when wr_l2req_valid && !stall_pipeline && (wr_cache_hit || wr_has_sm_data); a miss without sm data SHALL produce no response.
REQ-004 An accepted request SHALL be written into a 4-entry FIFO at the same rising edge.
REQ-005 The FIFO head SHALL drive the l2rsp_* outputs directly from registers, giving one-cycle latency from acceptance to l2rsp_valid.
REQ-006 l2rsp_valid SHALL equal FIFO non-empty.
REQ-007 The head SHALL dequeue on the edge where l2rsp_valid && l2rsp_ready.
REQ-008 While l2rsp_valid is high and l2rsp_ready is low, all l2rsp_* outputs SHALL hold stable.
REQ-009 Op mapping SHALL be: LOAD and LOAD_SYNC -> 0 (load ack); STORE and STORE_SYNC -> 1 (store ack); FLUSH -> 2; INVALIDATE -> 3.
REQ-010 l2rsp_status SHALL be 0 only for STORE_SYNC with wr_store_sync_success=0, and 1 otherwise.
REQ-011 For a store ack with status 1, l2rsp_update[i] SHALL equal the presence bit of core i in the wr_l1_has_line vector of the entry's unit (unit 0 -> core0 vector, unit 1 -> core1 vector); all other responses SHALL have l2rsp_update = 0.
REQ-012 l2rsp_way SHALL be the 2-bit slice of the selected wr_dir_l1_way vector for the requesting core on store acks, and wr_l2req_way otherwise.
REQ-013 l2rsp_data SHALL equal wr_data captured at acceptance.
REQ-014 The FIFO count SHALL be 0..4, incrementing on enqueue-only, decrementing on dequeue-only, and unchanged on simultaneous enqueue and dequeue.
REQ-015 Read and write pointers SHALL be 2 bits and wrap from 3 to 0.
REQ-016 rsp_stall SHALL be combinational and high when count >= 3, reserving one slot for the request already in flight.
REQ-017 Enqueue when count==4 with no same-cycle dequeue SHALL drop the request and leave FIFO contents and count unchanged.
REQ-018 Enqueue when count==4 with a same-cycle dequeue SHALL succeed.
REQ-019 Dequeue when empty SHALL be impossible, because l2rsp_valid is 0.

Reset
REQ-020 Asserting reset_n low SHALL, asynchronously, clear count and both pointers and drive l2rsp_valid=0 and rsp_overflow=0.
REQ-021 On reset, rsp_stall SHALL go to 0.
REQ-022 On reset, all other l2rsp_* outputs SHALL go to 0.
REQ-023 A reset asserted while the FIFO is non-empty SHALL discard all entries.
REQ-024 Operation SHALL resume on the first rising edge after reset_n deasserts.

Configuration
REQ-025 With L2_RSP_OVERFLOW_CHECK_EN defined, a dropped enqueue (REQ-017) SHALL set rsp_overflow, which SHALL stay high until reset, and a simulation $display error SHALL fire.
REQ-026 Without L2_RSP_OVERFLOW_CHECK_EN, rsp_overflow SHALL be tied 0, no overflow detection logic SHALL exist, and drop behaviour SHALL be unchanged.

Verification
REQ-027 Load hit (op=LOAD, hit=1, core=1, unit=2, strand=3, data=512'hA5..A5, ready=1) -> one cycle later: valid=1, op=0, status=1, core=1, strand=3, data=A5..A5, update=0; valid=0 the following cycle.
REQ-028 STORE_SYNC with sync_success=0 -> status=0, op=1, update=0; the same with sync_success=1 and has_line_core0=2'b10 on unit 0 -> status=1, update=2'b10.
REQ-029 Miss (hit=0, has_sm_data=0, valid=1) -> no l2rsp_valid for 5 cycles.
REQ-030 Hold ready=0 and issue 3 accepted requests -> rsp_stall=1 once count reaches 3; a 4th in-flight request is stored; release ready -> 4 responses emitted in issue order.
REQ-031 Force a 5th enqueue with ready=0 and count=4 -> entry dropped, count stays 4; rsp_overflow=1 if L2_RSP_OVERFLOW_CHECK_EN is defined, else 0.
REQ-032 Drop reset_n mid-stream with 2 entries queued -> l2rsp_valid=0 immediately, no stale response after reset release.
